// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the 6502 interrupt sequencer: states, source codes, vectors, P masks.
// INTERRUPT_SEQUENCER_BRK_EN selects whether a BRK source sets the B bit in the pushed status.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_LOAD_PC
    } state_t;

    localparam logic [1:0] INT_SRC_RES = 2'b00;
    localparam logic [1:0] INT_SRC_NMI = 2'b01;
    localparam logic [1:0] INT_SRC_IRQ = 2'b10;
    localparam logic [1:0] INT_SRC_BRK = 2'b11;

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_RES_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

    localparam logic [7:0] P_B_MASK = 8'h10;
    localparam logic [7:0] P_U_MASK = 8'h20;

    // Status byte as pushed: unused bit always 1, B bit only for a BRK entry.
    function automatic logic [7:0] push_status(input logic [7:0] p, input logic [1:0] src);
        logic [7:0] r;
        r = p | P_U_MASK;
`ifdef INTERRUPT_SEQUENCER_BRK_EN
        if (src == INT_SRC_BRK) begin
            r = r | P_B_MASK;
        end
`else
        if (src == INT_SRC_BRK) begin
            r = r | P_B_MASK;
        end
        r = r & ~P_B_MASK;
`endif
        return r;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector: remembers the previous pin value and holds a pending flag
// until the sequencer consumes it at the vector latch.
module nmi_edge_detect (
    input  logic clk,
    input  logic res,
    input  logic nmi,
    input  logic clr,
    output logic nmi_pending
);

    logic prev_q, prev_d;
    logic pending_q, pending_d;

    // A new edge in the same cycle as the clear wins, so it is never lost.
    always_comb begin
        prev_d    = nmi;
        pending_d = (prev_q & ~nmi) | (pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (!res) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign nmi_pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: three stack pushes, two vector reads, PC load.
// Define INTERRUPT_SEQUENCER_BRK_EN to honour the decoder's brk pulse.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VEC    = DEF_NMI_VEC,
    parameter logic [15:0] RES_VEC    = DEF_RES_VEC,
    parameter logic [15:0] IRQ_VEC    = DEF_IRQ_VEC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        irq,
    input  logic        nmi,
    input  logic        i_flag,
    input  logic        instr_boundary,
    input  logic        brk,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [15:0] addr,
    output logic [7:0]  data_out,
    output logic        rw,
    output logic        sp_dec,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        set_i,
    output logic        int_ack,
    output logic [1:0]  int_src
);

    state_t      state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        nmi_pending;
    logic        nmi_clr;
    logic        brk_take;

`ifdef INTERRUPT_SEQUENCER_BRK_EN
    assign brk_take = brk;
`else
    logic unused_brk;
    assign unused_brk = brk;
    assign brk_take   = 1'b0;
`endif

    // Pending NMI is consumed only when it actually redirects the vector.
    assign nmi_clr = (state_q == ST_PUSH_P) && rdy && (src_q != INT_SRC_RES) && nmi_pending;

    nmi_edge_detect u_nmi_edge_detect (
        .clk         (clk),
        .res         (res),
        .nmi         (nmi),
        .clr         (nmi_clr),
        .nmi_pending (nmi_pending)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        vec_d   = vec_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (rdy) begin
            case (state_q)
                ST_RST: begin
                    state_d = ST_PUSH_PCH;
                    src_d   = INT_SRC_RES;
                end
                ST_IDLE: begin
                    if (instr_boundary && nmi_pending) begin
                        state_d = ST_PUSH_PCH;
                        src_d   = INT_SRC_NMI;
                    end else if (instr_boundary && !irq && !i_flag) begin
                        state_d = ST_PUSH_PCH;
                        src_d   = INT_SRC_IRQ;
                    end else if (brk_take) begin
                        state_d = ST_PUSH_PCH;
                        src_d   = INT_SRC_BRK;
                    end
                end
                ST_PUSH_PCH: state_d = ST_PUSH_PCL;
                ST_PUSH_PCL: state_d = ST_PUSH_P;
                ST_PUSH_P: begin
                    state_d = ST_VEC_LO;
                    if (src_q == INT_SRC_RES) begin
                        vec_d = RES_VEC;
                    end else if (nmi_pending) begin
                        // A late NMI hijacks an IRQ/BRK entry that has already pushed its frame.
                        vec_d = NMI_VEC;
                        src_d = INT_SRC_NMI;
                    end else begin
                        vec_d = IRQ_VEC;
                    end
                end
                ST_VEC_LO: begin
                    state_d = ST_VEC_HI;
                    lo_d    = data_in;
                end
                ST_VEC_HI: begin
                    state_d = ST_LOAD_PC;
                    hi_d    = data_in;
                end
                ST_LOAD_PC: state_d = ST_IDLE;
                default:    state_d = ST_RST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
        if (!res) begin
            state_q <= ST_RST;
            src_q   <= INT_SRC_RES;
            vec_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            vec_q   <= vec_d;
        end
    end

    // Moore outputs; the strobes are gated by rdy so a frozen cycle never commits twice.
    always_comb begin
        busy     = 1'b1;
        addr     = 16'h0000;
        data_out = 8'h00;
        rw       = 1'b1;
        sp_dec   = 1'b0;
        pc_load  = 1'b0;
        pc_value = 16'h0000;
        set_i    = 1'b0;
        int_ack  = 1'b0;
        int_src  = 2'b00;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
                addr   = {STACK_PAGE, sp_in};
                rw     = (src_q == INT_SRC_RES);
                sp_dec = rdy;
                if (state_q == ST_PUSH_PCH) begin
                    data_out = pc_in[15:8];
                end else if (state_q == ST_PUSH_PCL) begin
                    data_out = pc_in[7:0];
                end else begin
                    data_out = push_status(p_in, src_q);
                end
            end
            ST_VEC_LO: addr = vec_q;
            ST_VEC_HI: addr = vec_q + 16'd1;
            ST_LOAD_PC: begin
                pc_load  = rdy;
                pc_value = {hi_q, lo_q};
                set_i    = 1'b1;
                int_ack  = rdy;
                int_src  = src_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed plus randomized bench for interrupt_sequencer against a bus-cycle level reference.
module tb_interrupt_sequencer;

    localparam logic [1:0] S_RES = 2'b00;
    localparam logic [1:0] S_NMI = 2'b01;
    localparam logic [1:0] S_IRQ = 2'b10;
    localparam logic [1:0] S_BRK = 2'b11;

    logic        clk;
    logic        res, rdy, irq, nmi, i_flag, instr_boundary, brk;
    logic [15:0] pc_in;
    logic [7:0]  p_in, sp_in, data_in;
    logic        busy, rw, sp_dec, pc_load, set_i, int_ack;
    logic [15:0] addr, pc_value;
    logic [7:0]  data_out;
    logic [1:0]  int_src;

    logic [7:0]  vmem [0:5];
    logic [15:0] vofs;

    int n_pass  = 0;
    int n_total = 0;

    interrupt_sequencer dut (
        .clk            (clk),
        .res            (res),
        .rdy            (rdy),
        .irq            (irq),
        .nmi            (nmi),
        .i_flag         (i_flag),
        .instr_boundary (instr_boundary),
        .brk            (brk),
        .pc_in          (pc_in),
        .p_in           (p_in),
        .sp_in          (sp_in),
        .data_in        (data_in),
        .busy           (busy),
        .addr           (addr),
        .data_out       (data_out),
        .rw             (rw),
        .sp_dec         (sp_dec),
        .pc_load        (pc_load),
        .pc_value       (pc_value),
        .set_i          (set_i),
        .int_ack        (int_ack),
        .int_src        (int_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector ROM at FFFA..FFFF; everything else reads as zero.
    always_comb begin
        vofs    = addr - 16'hFFFA;
        data_in = 8'h00;
        if (addr >= 16'hFFFA) begin
            data_in = vmem[vofs[2:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] p_model(input logic [1:0] src, input logic [7:0] p);
        logic [7:0] r;
        r = p | 8'h20;
`ifdef INTERRUPT_SEQUENCER_BRK_EN
        if (src == S_BRK) r = r | 8'h10;
`else
        r = r & 8'hEF;
`endif
        return r;
    endfunction

    // Expects the DUT to be in its first push cycle; walks the 6-cycle entry and the return to idle.
    task automatic run_seq(input logic [1:0] push_src, input logic [1:0] fin_src,
                           input logic [15:0] vec, input int stall_k, input int nmi_k);
        logic [7:0]  sp0;
        logic [7:0]  ebyte;
        logic [15:0] eaddr;
        logic [15:0] epc;
        int          vi;
        sp0 = sp_in;
        vi  = int'(vec) - 65530;
        epc = {vmem[vi + 1], vmem[vi]};
        for (int k = 0; k < 6; k++) begin
            eaddr = 16'h0000;
            chk("seq_busy", 32'(busy), 32'd1);
            if (k < 3) begin
                eaddr = {8'h01, sp0 - 8'(k)};
                if (k == 0)      ebyte = pc_in[15:8];
                else if (k == 1) ebyte = pc_in[7:0];
                else             ebyte = p_model(push_src, p_in);
                chk("push_addr", 32'(addr), 32'(eaddr));
                chk("push_rw", 32'(rw), 32'(push_src == S_RES));
                chk("push_sp_dec", 32'(sp_dec), 32'd1);
                chk("push_data", 32'(data_out), 32'(ebyte));
            end else if (k < 5) begin
                eaddr = vec + 16'(k - 3);
                chk("vec_addr", 32'(addr), 32'(eaddr));
                chk("vec_rw", 32'(rw), 32'd1);
                chk("vec_sp_dec", 32'(sp_dec), 32'd0);
                chk("vec_pc_load", 32'(pc_load), 32'd0);
            end else begin
                chk("load_pc_load", 32'(pc_load), 32'd1);
                chk("load_pc_value", 32'(pc_value), 32'(epc));
                chk("load_int_ack", 32'(int_ack), 32'd1);
                chk("load_int_src", 32'(int_src), 32'(fin_src));
                chk("load_set_i", 32'(set_i), 32'd1);
            end
            if (k == nmi_k) nmi = 1'b0;
            if (k == stall_k) begin
                rdy = 1'b0;
                repeat (2) begin
                    tick();
                    chk("stall_busy", 32'(busy), 32'd1);
                    chk("stall_sp_dec", 32'(sp_dec), 32'd0);
                    chk("stall_int_ack", 32'(int_ack), 32'd0);
                    chk("stall_pc_load", 32'(pc_load), 32'd0);
                    if (k < 5) chk("stall_addr", 32'(addr), 32'(eaddr));
                end
                rdy = 1'b1;
            end
            if (k < 3) sp_in = sp_in - 8'd1;
            tick();
        end
        chk("post_idle_busy", 32'(busy), 32'd0);
        chk("post_pc_load", 32'(pc_load), 32'd0);
    endtask

    task automatic fire_irq();
        i_flag = 1'b0;
        irq = 1'b0;
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        irq = 1'b1;
    endtask

    task automatic boundary_no_entry(input string tag);
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int mode;
        int sk;
        res = 1'b0; rdy = 1'b1; irq = 1'b1; nmi = 1'b1; i_flag = 1'b1;
        instr_boundary = 1'b0; brk = 1'b0;
        pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'hFF;
        for (int i = 0; i < 6; i++) vmem[i] = 8'(i + 1);

        // Reset held three cycles
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_rw", 32'(rw), 32'd1);
        chk("rst_sp_dec", 32'(sp_dec), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_value", 32'(pc_value), 32'd0);
        chk("rst_set_i", 32'(set_i), 32'd0);
        chk("rst_int_ack", 32'(int_ack), 32'd0);
        chk("rst_int_src", 32'(int_src), 32'd0);

        vmem[2] = 8'h34; vmem[3] = 8'h12;
        res = 1'b1;
        tick();
        run_seq(S_RES, S_RES, 16'hFFFC, -1, -1);

        // Directed IRQ entry
        pc_in = 16'h8005; p_in = 8'h02; sp_in = 8'hFD;
        vmem[4] = 8'hC3; vmem[5] = 8'hA5;
        fire_irq();
        run_seq(S_IRQ, S_IRQ, 16'hFFFE, -1, -1);

        // Masked IRQ over 20 boundaries
        i_flag = 1'b1;
        irq = 1'b0;
        for (int i = 0; i < 20; i++) boundary_no_entry("masked_irq_busy");
        irq = 1'b1;

`ifdef INTERRUPT_SEQUENCER_BRK_EN
        // BRK hijacked by an NMI edge during the PCL push
        pc_in = 16'h4002; p_in = 8'h81; sp_in = 8'hF0;
        vmem[0] = 8'h11; vmem[1] = 8'h22;
        brk = 1'b1;
        tick();
        brk = 1'b0;
        run_seq(S_BRK, S_NMI, 16'hFFFA, -1, 1);
        nmi = 1'b1;
        i_flag = 1'b1;
        boundary_no_entry("brk_hijack_pending_cleared");

        // brk together with a taken IRQ: IRQ wins
        i_flag = 1'b0; irq = 1'b0; brk = 1'b1; instr_boundary = 1'b1;
        tick();
        brk = 1'b0; instr_boundary = 1'b0; irq = 1'b1;
        run_seq(S_IRQ, S_IRQ, 16'hFFFE, -1, -1);
`else
        brk = 1'b1;
        tick();
        brk = 1'b0;
        chk("brk_ignored_busy", 32'(busy), 32'd0);
`endif

        // IRQ hijacked by an NMI edge during the PCL push
        pc_in = 16'h1357; p_in = 8'h40; sp_in = 8'hE8;
        vmem[0] = 8'h5A; vmem[1] = 8'hE1;
        fire_irq();
        run_seq(S_IRQ, S_NMI, 16'hFFFA, -1, 1);
        nmi = 1'b1;
        i_flag = 1'b1;
        boundary_no_entry("irq_hijack_pending_cleared");

        // Late NMI during a stalled vector-high read stays pending
        pc_in = 16'h2468; p_in = 8'h03; sp_in = 8'hC0;
        vmem[4] = 8'h0F; vmem[5] = 8'hF0;
        fire_irq();
        run_seq(S_IRQ, S_IRQ, 16'hFFFE, 4, 4);
        nmi = 1'b1;
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        run_seq(S_NMI, S_NMI, 16'hFFFA, -1, -1);

        // Randomized entries, optional stall anywhere in the sequence
        for (int it = 0; it < 10; it++) begin
            pc_in = 16'($urandom);
            p_in  = 8'($urandom);
            sp_in = 8'($urandom);
            for (int i = 0; i < 6; i++) vmem[i] = 8'($urandom);
            mode = int'($urandom_range(0, 1));
            sk   = int'($urandom_range(0, 6)) - 1;
            if (mode == 1) begin
                i_flag = 1'($urandom);
                nmi = 1'b0;
                tick();
                nmi = 1'b1;
                irq = 1'($urandom);
                instr_boundary = 1'b1;
                tick();
                instr_boundary = 1'b0;
                irq = 1'b1;
                run_seq(S_NMI, S_NMI, 16'hFFFA, sk, -1);
            end else begin
                fire_irq();
                run_seq(S_IRQ, S_IRQ, 16'hFFFE, sk, -1);
            end
        end

        // Reset arriving in the status push aborts the IRQ entry
        pc_in = 16'h0BAD; p_in = 8'h00; sp_in = 8'hFD;
        fire_irq();
        tick();
        tick();
        chk("mid_push_p_rw", 32'(rw), 32'd0);
        res = 1'b0;
        tick();
        chk("mid_rst_rw", 32'(rw), 32'd1);
        chk("mid_rst_sp_dec", 32'(sp_dec), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        res = 1'b1;
        vmem[2] = 8'h78; vmem[3] = 8'h56;
        tick();
        run_seq(S_RES, S_RES, 16'hFFFC, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
